// File: rtl/counter_8b.sv
// rtl/counter_8b.sv - free-running up-counter with synchronous active-high reset
//
// Purpose: counts rising clock edges and presents the running count.
// Ports:
//   value  out  WIDTH  current count, straight from the state register
//   clk    in   1      rising-edge clock, sole clock domain
//   reset  in   1      synchronous active-high reset, loads RESET_VALUE
module counter_8b #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0,
  parameter int STEP        = 1
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  // Parameters are truncated to the counter width; the add then wraps
  // naturally modulo 2**WIDTH with no carry out kept.
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RST_W;
    end else begin
      value <= value + STEP_W;
    end
  end

endmodule

// File: tb/tb_counter_8b.sv
// tb/tb_counter_8b.sv - randomized self-checking bench for counter_8b
`timescale 1ns/1ps
module tb_counter_8b;

  logic       clk;
  logic       reset;
  logic [7:0] value;

  int checks = 0;
  int errors = 0;

  // Reference: the count is simply the number of non-reset edges since the
  // most recent reset edge, reduced modulo 256. known stays 0 until a reset
  // edge has been seen (power-up value is undefined).
  int   since_reset = 0;
  bit   known       = 0;
  logic [7:0] prev_value;

  counter_8b #(.WIDTH(8), .RESET_VALUE(0), .STEP(1)) dut (
    .value(value),
    .clk  (clk),
    .reset(reset)
  );

  // Period 2, posedges at odd times.
  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive reset off-edge, let one posedge happen, sample on the following negedge.
  task automatic tick(input bit r, input string tag);
    prev_value = value;
    reset = r;
    @(posedge clk);
    if (r) begin
      since_reset = 0;
      known       = 1;
    end else begin
      since_reset++;
    end
    @(negedge clk);
    if (known) begin
      check(tag, value, 8'(since_reset % 256));
      if (!r && since_reset > 1)
        check({tag, "_delta"}, value, 8'((int'(prev_value) + 1) % 256));
    end
  endtask

  initial begin
    reset = 1'b1;

    // Reset through edge 33, release at t=34.
    repeat (17) tick(1'b1, "reset_hold");
    check("reset_state", value, 8'h00);
    tick(1'b0, "first_edge");
    check("edge35", value, 8'h01);
    tick(1'b0, "second_edge");
    check("edge37", value, 8'h02);

    // Continue to 270 edges after release, passing through the wrap.
    for (int i = 2; i < 270; i++) begin
      tick(1'b0, "run");
      if (i == 254) check("at_ff", value, 8'hff);
      if (i == 255) check("wrap", value, 8'h00);
    end
    check("edges_270", value, 8'h0e);

    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) tick(1'b1, "reset5");
    check("reset5_end", value, 8'h00);

    // Count to 0x37, then a single-edge reset pulse.
    for (int i = 0; i < 8'h37; i++) tick(1'b0, "to_37");
    check("at_37", value, 8'h37);
    tick(1'b1, "pulse");
    check("pulse_zero", value, 8'h00);
    tick(1'b0, "after_pulse");
    check("after_pulse_one", value, 8'h01);

    // Random reset pattern with occasional long runs that cross the wrap.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 39) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
